// File: rtl/uart_protocol_host_if.sv
// Request/response and UART character signals of uart_protocol_host, bundled
// for the host engine (master) and the protocol initiator (slave).
interface uart_protocol_host_if;
  logic        i_req;
  logic [1:0]  i_op;
  logic [15:0] i_addr;
  logic [7:0]  i_wdat;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_rdat;
  logic        i_uart_send_ready;
  logic        o_uart_send_pulse;
  logic [7:0]  o_uart_dat;
  logic        i_uart_received_pulse;
  logic [7:0]  i_uart_dat;

  modport slave (
    input  i_req, i_op, i_addr, i_wdat,
    input  i_uart_send_ready, i_uart_received_pulse, i_uart_dat,
    output o_busy, o_done, o_err, o_rdat,
    output o_uart_send_pulse, o_uart_dat
  );

  modport master (
    output i_req, i_op, i_addr, i_wdat,
    output i_uart_send_ready, i_uart_received_pulse, i_uart_dat,
    input  o_busy, o_done, o_err, o_rdat,
    input  o_uart_send_pulse, o_uart_dat
  );
endinterface

// File: rtl/uart_protocol_host.sv
// Host initiator for the ASCII protocol L<addr4>/W<dat2>/R/*; sequential-address
// skipping is built only when UART_PROTOCOL_HOST_ADDR_CACHE_EN is defined.
module uart_protocol_host #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  uart_protocol_host_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND_L, ST_SEND_A, ST_SEND_CMD, ST_SEND_D, ST_GAP, ST_WAIT_R, ST_DONE
  } state_t;

  function automatic logic [7:0] hex_enc(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

  // Returns {valid, nibble}; only '0'-'9' and 'a'-'f' are valid.
  function automatic logic [4:0] hex_dec(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39)      return {1'b1, ch[3:0]};
    else if (ch >= 8'h61 && ch <= 8'h66) return {1'b1, ch[3:0] + 4'd9};
    else                                 return 5'h00;
  endfunction

  state_t      state_r, state_s, ret_r, ret_s;
  logic [1:0]  idx_r, idx_s, op_r, op_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdat_r, wdat_s, rdat_r, rdat_s;
  logic        err_r, err_s, got_hi_r, got_hi_s;
  logic [3:0]  hi_r, hi_s, addr_nib_s;
  logic [31:0] cnt_r, cnt_s;
  logic        pulse_s, cache_hit_s;
  logic [7:0]  tx_dat_s;
  logic [4:0]  dec_s;

  assign dec_s = hex_dec(bus.i_uart_dat);

  // Address nibble currently being sent, MSB first.
  always_comb begin
    addr_nib_s = 4'h0;
    case (idx_r)
      2'd0:    addr_nib_s = addr_r[15:12];
      2'd1:    addr_nib_s = addr_r[11:8];
      2'd2:    addr_nib_s = addr_r[7:4];
      2'd3:    addr_nib_s = addr_r[3:0];
      default: addr_nib_s = 4'h0;
    endcase
  end

  // Next-state, datapath next values and the combinational send strobe.
  always_comb begin
    state_s  = state_r;  ret_s  = ret_r;  idx_s  = idx_r;   op_s = op_r;
    addr_s   = addr_r;   wdat_s = wdat_r; rdat_s = rdat_r;  err_s = err_r;
    got_hi_s = got_hi_r; hi_s   = hi_r;   cnt_s  = cnt_r;
    pulse_s  = 1'b0;     tx_dat_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req) begin
          op_s = bus.i_op; addr_s = bus.i_addr; wdat_s = bus.i_wdat;
          err_s = 1'b0; cnt_s = 32'd0; got_hi_s = 1'b0;
          case (bus.i_op)
            2'd0, 2'd1: state_s = cache_hit_s ? ST_SEND_CMD : ST_SEND_L;
            2'd2:       state_s = ST_SEND_CMD;
            default: begin
              state_s = ST_DONE;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND_L: begin
        tx_dat_s = 8'h4c;
        if (bus.i_uart_send_ready) begin
          pulse_s = 1'b1; idx_s = 2'd0; ret_s = ST_SEND_A; state_s = ST_GAP;
        end else begin
          state_s = ST_SEND_L;
        end
      end
      ST_SEND_A: begin
        tx_dat_s = hex_enc(addr_nib_s);
        if (bus.i_uart_send_ready) begin
          pulse_s = 1'b1;
          idx_s   = idx_r + 2'd1;
          ret_s   = (idx_r == 2'd3) ? ST_SEND_CMD : ST_SEND_A;
          state_s = ST_GAP;
        end else begin
          state_s = ST_SEND_A;
        end
      end
      ST_SEND_CMD: begin
        case (op_r)
          2'd0:    tx_dat_s = 8'h52;
          2'd1:    tx_dat_s = 8'h57;
          default: tx_dat_s = 8'h2a;
        endcase
        if (bus.i_uart_send_ready) begin
          pulse_s = 1'b1;
          // Last character of a read or remote reset needs no gap: no pulse follows.
          case (op_r)
            2'd0: begin
              state_s = ST_WAIT_R; cnt_s = 32'd0; got_hi_s = 1'b0;
            end
            2'd1: begin
              idx_s = 2'd0; ret_s = ST_SEND_D; state_s = ST_GAP;
            end
            default: begin
              state_s = ST_DONE; err_s = 1'b0;
            end
          endcase
        end else begin
          state_s = ST_SEND_CMD;
        end
      end
      ST_SEND_D: begin
        tx_dat_s = idx_r[0] ? hex_enc(wdat_r[3:0]) : hex_enc(wdat_r[7:4]);
        if (bus.i_uart_send_ready) begin
          pulse_s = 1'b1;
          if (idx_r[0]) begin
            state_s = ST_DONE; err_s = 1'b0;
          end else begin
            idx_s = 2'd1; ret_s = ST_SEND_D; state_s = ST_GAP;
          end
        end else begin
          state_s = ST_SEND_D;
        end
      end
      ST_GAP: state_s = ret_r;
      ST_WAIT_R: begin
        if (bus.i_uart_received_pulse) begin
          cnt_s = 32'd0;
          if (!dec_s[4]) begin
            state_s = ST_DONE; err_s = 1'b1;
          end else if (got_hi_r) begin
            rdat_s = {hi_r, dec_s[3:0]}; state_s = ST_DONE; err_s = 1'b0;
          end else begin
            hi_s = dec_s[3:0]; got_hi_s = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_r + 32'd1 >= TIMEOUT_CYCLES)) begin
          state_s = ST_DONE; err_s = 1'b1; cnt_s = cnt_r + 32'd1;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE; ret_r <= ST_IDLE; idx_r <= 2'd0; op_r <= 2'd0;
      addr_r <= 16'h0000; wdat_r <= 8'h00; rdat_r <= 8'h00; err_r <= 1'b0;
      got_hi_r <= 1'b0; hi_r <= 4'h0; cnt_r <= 32'd0;
    end else begin
      state_r <= state_s; ret_r <= ret_s; idx_r <= idx_s; op_r <= op_s;
      addr_r <= addr_s; wdat_r <= wdat_s; rdat_r <= rdat_s; err_r <= err_s;
      got_hi_r <= got_hi_s; hi_r <= hi_s; cnt_r <= cnt_s;
    end
  end

`ifdef UART_PROTOCOL_HOST_ADDR_CACHE_EN
  logic        cache_valid_r, cache_valid_s;
  logic [15:0] next_addr_r, next_addr_s;

  assign cache_hit_s = cache_valid_r && (bus.i_addr == next_addr_r);

  // Success arms the cache with addr+1; read errors and remote reset clear it.
  always_comb begin
    cache_valid_s = cache_valid_r;
    next_addr_s   = next_addr_r;
    if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
      if (!op_s[1] && !err_s) begin
        cache_valid_s = 1'b1;
        next_addr_s   = addr_r + 16'd1;
      end else if ((op_s == 2'd2) || ((op_s == 2'd0) && err_s)) begin
        cache_valid_s = 1'b0;
      end else begin
        cache_valid_s = cache_valid_r;
      end
    end else begin
      cache_valid_s = cache_valid_r;
    end
  end

  // Address cache registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cache_valid_r <= 1'b0;
      next_addr_r   <= 16'h0000;
    end else begin
      cache_valid_r <= cache_valid_s;
      next_addr_r   <= next_addr_s;
    end
  end
`else
  assign cache_hit_s = 1'b0;
`endif

  assign bus.o_busy            = (state_r != ST_IDLE);
  assign bus.o_done            = (state_r == ST_DONE);
  assign bus.o_err             = err_r;
  assign bus.o_rdat            = rdat_r;
  assign bus.o_uart_send_pulse = pulse_s;
  assign bus.o_uart_dat        = tx_dat_s;

endmodule

// File: doc/uart_protocol_host.md
Name: uart_protocol_host

Overview:
- Host-side initiator for the ASCII bus protocol `L<addr4>`, `W<dat2>`, `R`, `*`, with lowercase hex.
- Converts single bus requests (read, write, remote reset) into the character stream for a UART transmitter.
- For reads, parses the two returned hex characters from a UART receiver.
- Sits between a local test/control engine and the UART TX/RX pair that faces the remote protocol slave.

Parameters:
- TIMEOUT_CYCLES, 100000, cycles allowed between read-reply characters before the read fails; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_req  in  1  request strobe; sampled only while o_busy=0
- i_op  in  2  operation: 0 read, 1 write, 2 remote reset, 3 reserved
- i_addr  in  16  bus address
- i_wdat  in  8  write data
- o_busy  out  1  request in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  error flag; valid while o_done=1
- o_rdat  out  8  read data; valid from o_done until the next request
- i_uart_send_ready  in  1  UART TX can accept a character
- o_uart_send_pulse  out  1  one-cycle send strobe
- o_uart_dat  out  8  character to send; valid while o_uart_send_pulse=1
- i_uart_received_pulse  in  1  UART RX character strobe
- i_uart_dat  in  8  received character

Behaviour:
- Reset (i_reset_n=0 at a clock edge) gives:
  - o_busy=0, o_done=0, o_err=0, o_rdat=0x00
  - o_uart_send_pulse=0, o_uart_dat=0x00
  - FSM in IDLE, address cache invalid, timeout counter 0
- Reset mid-operation aborts immediately. No o_done is produced, and any partial character sequence is abandoned.
- Request acceptance:
  - i_req=1 with o_busy=0 latches i_op, i_addr and i_wdat.
  - o_busy=1 from the next cycle until the cycle of o_done, inclusive; o_busy=0 the cycle after.
  - i_req while o_busy=1 is ignored.
- States: IDLE, SEND_L, SEND_A, SEND_CMD, SEND_D, GAP, WAIT_R, DONE.
- Send rule:
  - In any SEND_* state, o_uart_send_pulse=1 exactly in cycles where i_uart_send_ready=1.
  - o_uart_dat holds the character in that same cycle.
  - Every send pulse is followed by one GAP cycle with no pulse, so there is at most one pulse per 2 cycles.
- Hex encoding: nibble 0-9 maps to 0x30+n; nibble a-f maps to 0x57+n (lowercase). Address is sent MSB nibble first.
- Write (op 1):
  - Address phase: SEND_L sends "L", then SEND_A sends 4 nibbles, unless the address cache hits.
  - SEND_CMD sends "W", then SEND_D sends data high nibble then low nibble.
  - DONE follows: o_done=1, o_err=0, the cycle after the last send pulse.
- Read (op 1 replaced by op 0):
  - Address phase as for write, then "R", then WAIT_R.
  - WAIT_R accepts two received characters: the first goes to rdat[7:4], the second to rdat[3:0].
  - Valid characters are '0'-'9' and 'a'-'f' only.
  - o_done is asserted the cycle after the second character.
  - Received characters outside WAIT_R are ignored.
- Read errors:
  - A non-hex character in WAIT_R gives o_done=1, o_err=1; o_rdat is left unchanged.
  - Timeout: the counter increments each WAIT_R cycle and clears on each received character. Reaching TIMEOUT_CYCLES gives o_done=1, o_err=1.
  - Either error invalidates the address cache.
- Remote reset (op 2): sends "*", then o_done, o_err=0. Invalidates the address cache.
- Reserved op (op 3): no characters are sent; o_done=1, o_err=1 the cycle after acceptance.
- Address cache (when enabled):
  - r_next_addr is set to latched addr+1 (16-bit, 0xffff wraps to 0x0000) at each successful read/write o_done; the cache becomes valid.
  - Address phase is skipped when the cache is valid and i_addr==r_next_addr.
- Simultaneous i_uart_received_pulse and a send pulse are both handled; RX and TX are independent.

Optional Feature:
- Macro: UART_PROTOCOL_HOST_ADDR_CACHE_EN.
- Defined: address cache behaves as above, and sequential accesses omit the "L" and 4 address characters.
- Undefined: "L" plus 4 address nibbles is sent on every read and write; no cache state is synthesized.

Test Plan:
- Write 0x4d to 0x1a00, ready always 1 -> TX "L1a00W4d" (8 pulses, 2 cycles apart); o_done, o_err=0; o_busy low the next cycle.
- Read 0x1234, bench replies "b7" -> TX "L1234R"; o_rdat=0xb7, o_err=0.
- With cache enabled: write 0xffff then write 0x0000 -> second request sends only "W"+2 nibbles. Without the macro it sends "L0000W..".
- Read with reply "G" -> o_err=1, o_rdat unchanged. A following read of addr+1 re-sends "L" (cache invalidated).
- Read with no reply, TIMEOUT_CYCLES=50 -> o_done with o_err=1 50 cycles after entering WAIT_R.
- Op 2 -> TX "*" then o_done. Op 3 -> o_err=1 with zero send pulses.
- Reset mid-address: i_reset_n=0 after 2 nibbles -> no further pulses, o_busy=0, no o_done.
